// File: rtl/fnd_scan.sv
// fnd_scan: four-digit time-multiplexed scanner that feeds a single-digit 7-segment decoder.
//
// Holds four packed 4-bit digits and lights them one at a time, with an all-off blanking gap
// between digits to prevent ghosting. A captured value is applied only at the frame wrap
// (digit 3 -> digit 0), so a frame never mixes old and new digits.
//
// Optional feature macro: FND_LZB_EN (leading-zero blanking). When defined, digits 1..3 stay
// dark during their lit phase if they and all higher digits are zero. Digit 0 is always lit.
//
// Ports:
//   i_Clk       clock, rising edge
//   i_Rst       asynchronous active-high reset
//   i_Data      packed digits, [3:0] = digit 0 (rightmost), [15:12] = digit 3
//   i_Load      single-cycle capture request for i_Data
//   o_Num       current digit value for the decoder
//   o_DigitSel  active-low one-hot digit select (bit n lights digit n)
//   o_Pending   a captured value is waiting for the frame wrap
//   o_Frame     one-cycle pulse on the digit 3 -> digit 0 wrap
module fnd_scan #(
  parameter int unsigned CLK_DIV   = 50000,
  parameter int unsigned BLANK_CYC = 16
) (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic [15:0] i_Data,
  input  logic        i_Load,
  output logic [3:0]  o_Num,
  output logic [3:0]  o_DigitSel,
  output logic        o_Pending,
  output logic        o_Frame
);

  localparam int unsigned CntMax = (CLK_DIV > BLANK_CYC) ? CLK_DIV : BLANK_CYC;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

  typedef enum logic {StBlank, StShow} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [15:0]       pend_q, pend_d;
  logic [15:0]       disp_q, disp_d;
  logic              pending_q, pending_d;
  logic [3:0]        num_q, num_d;
  logic [3:0]        sel_q, sel_d;
  logic              frame_q, frame_d;
  logic              digit_lit;

`ifdef FND_LZB_EN
  // A digit is dark only if it and every more-significant digit are zero.
  always_comb begin
    digit_lit = 1'b1;
    unique case (idx_q)
      2'd0: digit_lit = 1'b1;
      2'd1: digit_lit = |disp_q[15:4];
      2'd2: digit_lit = |disp_q[15:8];
      2'd3: digit_lit = |disp_q[15:12];
      default: digit_lit = 1'b1;
    endcase
  end
`else
  assign digit_lit = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    idx_d     = idx_q;
    pend_d    = pend_q;
    disp_d    = disp_q;
    pending_d = pending_q;
    num_d     = num_q;
    sel_d     = sel_q;
    frame_d   = 1'b0;

    unique case (state_q)
      StBlank: begin
        if (cnt_q == CntW'(BLANK_CYC - 1)) begin
          cnt_d   = '0;
          state_d = StShow;
          sel_d   = digit_lit ? ~(4'b0001 << idx_q) : 4'b1111;
        end
      end
      StShow: begin
        if (cnt_q == CntW'(CLK_DIV - 1)) begin
          cnt_d   = '0;
          state_d = StBlank;
          sel_d   = 4'b1111;
          idx_d   = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            frame_d = 1'b1;
            if (pending_q) begin
              disp_d    = pend_q;
              pending_d = 1'b0;
            end
          end
          // disp_d already reflects any frame-wrap update, so digit 0 shows the new value.
          num_d = disp_d[{idx_d, 2'b00} +: 4];
        end
      end
      default: state_d = StBlank;
    endcase

    // Applied after the wrap so a coincident load lands in pend while disp takes the old pend.
    if (i_Load) begin
      pend_d    = i_Data;
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q   <= StBlank;
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      pend_q    <= 16'h0000;
      disp_q    <= 16'h0000;
      pending_q <= 1'b0;
      num_q     <= 4'h0;
      sel_q     <= 4'b1111;
      frame_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      pend_q    <= pend_d;
      disp_q    <= disp_d;
      pending_q <= pending_d;
      num_q     <= num_d;
      sel_q     <= sel_d;
      frame_q   <= frame_d;
    end
  end

  assign o_Num      = num_q;
  assign o_DigitSel = sel_q;
  assign o_Pending  = pending_q;
  assign o_Frame    = frame_q;

endmodule

// File: tb/tb_fnd_scan.sv
// Self-checking bench for fnd_scan with CLK_DIV=4, BLANK_CYC=2 (24-cycle frame).
// The reference model derives every output from the number of clock edges since reset release
// plus the displayed/pending values, applying updates only at frame wraps.
module tb_fnd_scan;

  localparam int unsigned ClkDiv   = 4;
  localparam int unsigned BlankCyc = 2;
  localparam int unsigned DigPer   = ClkDiv + BlankCyc;
  localparam int unsigned FramePer = 4 * DigPer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] data;
  logic        load;
  logic [3:0]  num;
  logic [3:0]  sel;
  logic        pending;
  logic        frame;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int unsigned k;          // rising edges since reset release
  logic [15:0] disp_m;
  logic [15:0] pend_m;
  logic        pend_v;

  fnd_scan #(
    .CLK_DIV   (ClkDiv),
    .BLANK_CYC (BlankCyc)
  ) dut (
    .i_Clk      (clk),
    .i_Rst      (rst),
    .i_Data     (data),
    .i_Load     (load),
    .o_Num      (num),
    .o_DigitSel (sel),
    .o_Pending  (pending),
    .o_Frame    (frame)
  );

  always #5 clk = ~clk;

  function automatic logic lit_m(input int unsigned d, input logic [15:0] v);
`ifdef FND_LZB_EN
    return (d == 0) || ((v >> (4 * d)) != 16'h0000);
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_reset();
    k      = 0;
    disp_m = 16'h0000;
    pend_m = 16'h0000;
    pend_v = 1'b0;
  endtask

  task automatic model_edge(input logic ld, input logic [15:0] dat);
    k = k + 1;
    if (k % FramePer == 0 && pend_v) begin
      disp_m = pend_m;
      pend_v = 1'b0;
    end
    if (ld) begin
      pend_m = dat;
      pend_v = 1'b1;
    end
  endtask

  task automatic check_all();
    int unsigned d;
    int unsigned s;
    logic [3:0]  one;
    logic [3:0]  e_num;
    logic [3:0]  e_sel;
    logic        e_frame;
    one     = 4'b0001;
    d       = (k / DigPer) % 4;
    s       = k % DigPer;
    e_num   = disp_m[4*d +: 4];
    e_sel   = (s >= BlankCyc && lit_m(d, disp_m)) ? ~(one << d) : 4'b1111;
    e_frame = (k > 0) && (k % FramePer == 0);

    checks++;
    assert (num === e_num) else begin
      errors++;
      $error("FAIL num k=%0d got %h expected %h", k, num, e_num);
    end
    checks++;
    assert (sel === e_sel) else begin
      errors++;
      $error("FAIL digitsel k=%0d got %b expected %b", k, sel, e_sel);
    end
    checks++;
    assert (pending === pend_v) else begin
      errors++;
      $error("FAIL pending k=%0d got %b expected %b", k, pending, pend_v);
    end
    checks++;
    assert (frame === e_frame) else begin
      errors++;
      $error("FAIL frame k=%0d got %b expected %b", k, frame, e_frame);
    end
  endtask

  task automatic check_reset(input string tag);
    checks++;
    assert (num === 4'h0) else begin
      errors++;
      $error("FAIL %s num got %h expected 0", tag, num);
    end
    checks++;
    assert (sel === 4'b1111) else begin
      errors++;
      $error("FAIL %s digitsel got %b expected 1111", tag, sel);
    end
    checks++;
    assert (pending === 1'b0) else begin
      errors++;
      $error("FAIL %s pending got %b expected 0", tag, pending);
    end
    checks++;
    assert (frame === 1'b0) else begin
      errors++;
      $error("FAIL %s frame got %b expected 0", tag, frame);
    end
  endtask

  task automatic step(input logic ld, input logic [15:0] dat);
    load = ld;
    data = dat;
    @(posedge clk);
    model_edge(ld, dat);
    #1;
    check_all();
    load = 1'b0;
  endtask

  task automatic run_to(input int unsigned target);
    while (k < target) step(1'b0, 16'h0000);
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    data = 16'h0000;
    model_reset();
    #1;
    check_reset("por");
    @(posedge clk);
    #1;
    check_reset("por_hold");
    rst = 1'b0;

    // Scan order: 4321 becomes visible at the first wrap.
    step(1'b1, 16'h4321);
    run_to(48);

    // Frame-boundary apply: 1111 shown, then 8888 loaded during digit 1.
    step(1'b1, 16'h1111);
    run_to(79);
    step(1'b1, 16'h8888);
    run_to(100);

    // Overwrite within one frame: only 7 ever shows.
    step(1'b1, 16'h0005);
    run_to(109);
    step(1'b1, 16'h0007);
    run_to(150);

    // Load exactly on the wrap edge (168 = 7 frames).
    step(1'b1, 16'h0002);
    run_to(167);
    step(1'b1, 16'h0003);
    run_to(220);

    // Leading-zero patterns.
    step(1'b1, 16'h0070);
    run_to(270);
    step(1'b1, 16'h0000);
    run_to(320);
    step(1'b1, 16'h0300);
    run_to(370);

    // Reset mid-SHOW on digit 2 with a load in flight.
    step(1'b1, 16'hABCD);
    while (k % FramePer != 2 * DigPer + BlankCyc + 1) step(1'b0, 16'h0000);
    #2;
    rst = 1'b1;
    #1;
    check_reset("mid_reset");
    @(posedge clk);
    #1;
    check_reset("mid_reset_hold");
    rst = 1'b0;
    model_reset();
    run_to(30);

    // Randomized loads, with extra weight on the wrap edge.
    for (int i = 0; i < 800; i++) begin
      logic        ld;
      logic [15:0] dat;
      dat = 16'($urandom);
      if ((k + 1) % FramePer == 0) ld = ($urandom_range(0, 1) == 1);
      else                         ld = ($urandom_range(0, 9) == 0);
      // Occasionally bias toward small values to exercise leading zeros.
      if ($urandom_range(0, 3) == 0) dat = dat >> (4 * $urandom_range(1, 3));
      step(ld, dat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fnd_scan.md
# fnd_scan

Four-digit time-multiplexed scanner that sits directly upstream of the single-digit 7-segment decoder (`FND`). It holds a 16-bit packed value of four 4-bit digits and presents one digit at a time on `o_Num` for the decoder. It also drives an active-low one-hot digit-select bus to the display anodes. A blanking gap between digits prevents ghosting. New values are applied only at frame boundaries so a frame never shows mixed old and new digits.

## Interface

- `CLK_DIV`, default 50000: cycles each digit is lit; must be ≥ 2.
- `BLANK_CYC`, default 16: cycles all digits are off between digits; must be ≥ 1.
- `i_Clk` in, 1 bit: clock, rising edge.
- `i_Rst` in, 1 bit: reset, asynchronous, active-high.
- `i_Data` in, 16 bits: packed digits. `[3:0]` is digit 0 (rightmost); `[15:12]` is digit 3.
- `i_Load` in, 1 bit: single-cycle request to capture `i_Data`.
- `o_Num` out, 4 bits: current digit value, feeds the decoder's `i_Num`.
- `o_DigitSel` out, 4 bits: active-low one-hot select; bit n lights digit n.
- `o_Pending` out, 1 bit: high while a captured value awaits the frame boundary.
- `o_Frame` out, 1 bit: one-cycle pulse when the scan wraps from digit 3 to digit 0.

## Operation

- **Registers**
  - `pend`: 16 bits.
  - `disp`: 16 bits.
  - `idx`: 2 bits.
  - `cnt`: sized for `max(CLK_DIV, BLANK_CYC)`.
  - `state`: one of `BLANK` or `SHOW`.
- **Capture**
  - `i_Load`=1 sets `pend<=i_Data` and `o_Pending<=1`.
  - If a load is already pending, the new load overwrites it (last wins).
- **State `BLANK`**
  - `o_DigitSel=4'b1111`.
  - `o_Num` already holds `disp[idx]`.
  - `cnt` counts up. When `cnt==BLANK_CYC-1`: `cnt<=0`, `state<=SHOW`, `o_DigitSel<=~(4'b0001<<idx)`.
- **State `SHOW`**
  - `cnt` counts up. When `cnt==CLK_DIV-1`: `cnt<=0`, `state<=BLANK`, `o_DigitSel<=4'b1111`, `idx<=idx+1` (3 wraps to 0), `o_Num<=` the next digit.
- **Frame wrap** (SHOW→BLANK transition with `idx==3`)
  - `o_Frame<=1` for that one cycle.
  - If `o_Pending`: `disp<=pend`, `o_Pending<=0`, and `o_Num<=pend[3:0]`. Otherwise `o_Num<=disp[3:0]`.
- **Load coinciding with a frame wrap**
  - `disp` takes the old `pend`.
  - `pend` takes the new `i_Data`.
  - `o_Pending` stays 1.
- Digit values 0–F pass through unmodified. Decoding them is the downstream decoder's job.

## Timing

- **Reset values** (apply immediately on `i_Rst`, regardless of clock)
  - `o_Num=0`, `o_DigitSel=4'b1111`, `o_Pending=0`, `o_Frame=0`.
  - `state=BLANK`, `idx=0`, `cnt=0`, `disp=0`, `pend=0`.
- **Reset mid-operation**: an in-flight pending load is discarded. Scanning restarts with digit 0 blank phase after `i_Rst` deasserts.
- All outputs are registered. There is no combinational path from inputs to outputs.
- **Cycle counts**
  - Digit period: `BLANK_CYC+CLK_DIV` cycles.
  - Frame period: `4*(BLANK_CYC+CLK_DIV)` cycles.
  - First lit digit: `o_DigitSel[0]` goes low on the `BLANK_CYC`-th rising edge after reset release.
- **Load-to-display latency**: a capture becomes visible at the next frame wrap, at most one frame period plus 1 cycle.
- `o_DigitSel` never has more than one bit low. Every select change passes through `4'b1111` for at least `BLANK_CYC` cycles.

## Configuration

- Macro: `FND_LZB_EN` (leading-zero blanking).
- **With `FND_LZB_EN` defined**
  - During `SHOW` for digit n (n=1..3), `o_DigitSel` stays `4'b1111` if digits n..3 of `disp` are all zero.
  - Digit 0 is always lit.
  - Scan timing, `o_Num`, and `o_Frame` are unchanged.
- **Without it**: all four digits are lit every frame.

## Test plan

Common setup: `CLK_DIV=4`, `BLANK_CYC=2`, so the frame period is 24 cycles.

- **Reset.** Assert `i_Rst` mid-SHOW on digit 2. Required: `o_DigitSel=1111`, `o_Num=0`, `o_Pending=0` immediately. After release, `o_DigitSel=1110` appears after 2 cycles.
- **Scan order.** Load `16'h4321` and wait for the frame wrap. Required: `o_Num` sequence 1,2,3,4. `o_DigitSel` sequence 1110, 1101, 1011, 0111, each low for 4 cycles and separated by 2 cycles of 1111. `o_Frame` pulses every 24 cycles.
- **Frame-boundary apply.** Display `16'h1111`, then load `16'h8888` during digit 1. Required: digits 1–3 of that frame still show 1. `o_Pending`=1 until the wrap. Digit 0 of the next frame shows 8.
- **Overwrite.** Load `16'h0005` then `16'h0007` within one frame. Required: only 7 is ever displayed.
- **Load on wrap.** Have `16'h0002` pending, and load `16'h0003` in the exact wrap cycle. Required: the next frame shows `16'h0002`. `o_Pending` stays 1. The frame after that shows `16'h0003`.
- **Leading-zero blanking (`FND_LZB_EN`).** Display `16'h0070`. Required: digits 3 and 2 stay dark (1111 during their SHOW). Digits 1 and 0 are lit with 7 and 0. With `16'h0000`, only digit 0 is lit.
